// File: rtl/sifive_scope_tl_c_echo_tracer_if.sv
// Snoop bundle for the C-channel echo tracer: per-channel beat fields plus the drain port.
// Entry width grows by 16 bits when SIFIVE_SCOPE_TL_C_ECHO_TS_EN is defined.
interface sifive_scope_tl_c_echo_tracer_if #(
  parameter int NUM_CH = 2,
  parameter int ECHO_W = 4,
  parameter int ADDR_W = 32,
  parameter int CH_W   = 1
);
`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
  localparam int ENTRY_W = 16 + CH_W + 3 + ECHO_W + ADDR_W;
`else
  localparam int ENTRY_W = CH_W + 3 + ECHO_W + ADDR_W;
`endif

  logic [NUM_CH-1:0]        c_valid;
  logic [NUM_CH-1:0]        c_ready;
  logic [NUM_CH*3-1:0]      c_opcode;
  logic [NUM_CH*ECHO_W-1:0] c_echo;
  logic [NUM_CH*ADDR_W-1:0] c_address;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ENTRY_W-1:0]       rd_data;

  modport master (
    output c_valid, c_ready, c_opcode, c_echo, c_address, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  c_valid, c_ready, c_opcode, c_echo, c_address, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/sifive_scope_tl_c_echo_tracer.sv
// Trace buffer for TileLink C-channel beats, frozen a programmable distance after a trigger.
// Optional timestamp per entry: define SIFIVE_SCOPE_TL_C_ECHO_TS_EN.
module sifive_scope_tl_c_echo_tracer #(
  parameter int NUM_CH = 2,
  parameter int ECHO_W = 4,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  sifive_scope_tl_c_echo_tracer_if.slave bus,
  input  logic                          arm,
  input  logic [2:0]                    trig_opcode,
  input  logic [ECHO_W-1:0]             trig_echo_val,
  input  logic [ECHO_W-1:0]             trig_echo_msk,
  input  logic [$clog2(DEPTH):0]        post_cnt,
  output logic [1:0]                    state,
  output logic [7:0]                    dropped
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BASE_W = CH_W + 3 + ECHO_W + ADDR_W;
`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
  localparam int ENTRY_W = 16 + BASE_W;
`else
  localparam int ENTRY_W = BASE_W;
`endif
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // state | meaning
  // IDLE  | waiting for arm, snoop ignored
  // ARMED | capturing, watching for trigger
  // POST  | capturing the post-trigger beats
  // DONE  | window frozen, draining oldest-first
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_n;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]   count, count_n, remaining;
  logic               rd_valid_q;
  logic [ENTRY_W-1:0] rd_data_q;
  logic [NUM_CH-1:0]  fire;
  logic               any_fire, trig_hit, capture, pop;
  logic [CH_W-1:0]    sel;
  logic [2:0]         n_fire, sel_op;
  logic [ECHO_W-1:0]  sel_echo;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BASE_W-1:0]  beat;
  logic [ENTRY_W-1:0] entry;
  logic [8:0]         drop_sum;

  always_comb begin
    fire   = bus.c_valid & bus.c_ready;
    sel    = '0;
    n_fire = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (fire[i]) sel = CH_W'(i);
    for (int i = 0; i < NUM_CH; i++) n_fire = n_fire + {2'b00, fire[i]};
  end

  assign any_fire = |fire;
  assign sel_op   = bus.c_opcode[3*int'(sel) +: 3];
  assign sel_echo = bus.c_echo[ECHO_W*int'(sel) +: ECHO_W];
  assign sel_addr = bus.c_address[ADDR_W*int'(sel) +: ADDR_W];
  assign beat     = {sel, sel_op, sel_echo, sel_addr};
  assign trig_hit = (sel_op == trig_opcode) && (((sel_echo ^ trig_echo_val) & trig_echo_msk) == '0);
  assign capture  = any_fire && !arm && (state_q == ARMED || state_q == POST);
  assign pop      = (state_q == DONE) && rd_valid_q && bus.rd_ready && !arm;
  assign drop_sum = {1'b0, dropped} + (any_fire ? {6'd0, n_fire - 3'd1} : 9'd0);
  assign wr_ptr_n = capture ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign count_n  = (capture && count != FULL) ? count + CNT_W'(1) : count;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
  logic [15:0] ts;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 16'd1;
  end
  assign entry = {ts, beat};
`else
  assign entry = beat;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (arm) state_n = ARMED;
    else begin
      case (state_q)
        IDLE:    state_n = IDLE;
        ARMED:   if (capture && trig_hit) state_n = (post_cnt == '0) ? DONE : POST;
        POST:    if (capture && remaining == CNT_W'(1)) state_n = DONE;
        DONE:    if (count == '0 || (pop && count == CNT_W'(1))) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (capture) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      dropped    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      count      <= '0;
      dropped    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (state_q != IDLE) dropped <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      if (state_q == ARMED && capture && trig_hit) remaining <= post_cnt;
      else if (state_q == POST && capture)         remaining <= remaining - CNT_W'(1);
      // oldest entry sits count slots behind the write pointer, modulo DEPTH
      if (state_n == DONE && state_q != DONE) rd_ptr <= wr_ptr_n - count_n[PTR_W-1:0];
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
        count  <= count - CNT_W'(1);
        if (count == CNT_W'(1)) rd_valid_q <= 1'b0;
        else                    rd_data_q  <= mem[rd_ptr_inc];
      end else if (state_q == DONE && !rd_valid_q && count != '0) begin
        rd_data_q  <= mem[rd_ptr];
        rd_valid_q <= 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_sifive_scope_tl_c_echo_tracer.sv
// Self-checking bench for the C-channel echo tracer against a queue-based trace model.
`timescale 1ns/1ps
module tb_sifive_scope_tl_c_echo_tracer;
  localparam int NUM_CH = 2;
  localparam int ECHO_W = 4;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 1;
  localparam int BASE_W = CH_W + 3 + ECHO_W + ADDR_W;
`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
  localparam int ENTRY_W = 16 + BASE_W;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       arm = 1'b0;
  logic [2:0] trig_opcode = '0;
  logic [3:0] trig_echo_val = '0;
  logic [3:0] trig_echo_msk = '0;
  logic [4:0] post_cnt = '0;
  logic [1:0] state;
  logic [7:0] dropped;

  sifive_scope_tl_c_echo_tracer_if #(.NUM_CH(NUM_CH), .ECHO_W(ECHO_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

  sifive_scope_tl_c_echo_tracer #(.NUM_CH(NUM_CH), .ECHO_W(ECHO_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .arm(arm), .trig_opcode(trig_opcode),
    .trig_echo_val(trig_echo_val), .trig_echo_msk(trig_echo_msk), .post_cnt(post_cnt),
    .state(state), .dropped(dropped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference: 0 idle, 1 armed, 2 post, 3 done; buffer is a queue of {ch, op, echo, addr}
  int m_state, m_rem, m_dropped;
  bit m_rdv;
  logic [BASE_W-1:0] m_q[$];

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_dropped = 0; m_rdv = 0; m_q.delete();
  endtask

  task automatic model_edge();
    int lo, nf;
    logic [2:0] op;
    logic [3:0] ec;
    logic [31:0] ad;
    if (!reset_n) begin model_reset(); return; end
    lo = -1; nf = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.c_valid[i] && bus.c_ready[i]) begin nf++; if (lo < 0) lo = i; end
    if (arm) begin m_q.delete(); m_dropped = 0; m_rdv = 0; m_state = 1; return; end
    if (m_state != 0 && nf > 1) m_dropped = (m_dropped + nf - 1 > 255) ? 255 : m_dropped + nf - 1;
    if (lo >= 0 && (m_state == 1 || m_state == 2)) begin
      op = bus.c_opcode[lo*3 +: 3];
      ec = bus.c_echo[lo*4 +: 4];
      ad = bus.c_address[lo*32 +: 32];
      m_q.push_back({CH_W'(lo), op, ec, ad});
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      if (m_state == 1) begin
        if (op == trig_opcode && ((ec ^ trig_echo_val) & trig_echo_msk) == 4'd0) begin
          if (post_cnt == 0) m_state = 3;
          else begin m_state = 2; m_rem = int'(post_cnt); end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end else if (m_state == 3) begin
      if (m_rdv && bus.rd_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin m_rdv = 0; m_state = 0; end
      end else if (!m_rdv && m_q.size() != 0) m_rdv = 1;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.c_valid   = '0;
    bus.c_ready   = NUM_CH'($urandom);
    bus.c_opcode  = 6'($urandom);
    bus.c_echo    = 8'($urandom);
    bus.c_address = {$urandom, $urandom};
  endtask

  task automatic drive(input int ch, input logic [2:0] op, input logic [3:0] ec, input logic [31:0] ad);
    bus.c_valid[ch]          = 1'b1;
    bus.c_ready[ch]          = 1'b1;
    bus.c_opcode[ch*3 +: 3]  = op;
    bus.c_echo[ch*4 +: 4]    = ec;
    bus.c_address[ch*32 +: 32] = ad;
  endtask

  task automatic do_arm();
    idle(); arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.rd_ready = 1'b0; idle(); model_reset();
    cyc(); cyc();
    checks++;
    if (state !== 2'b00 || bus.rd_valid !== 1'b0 || dropped !== 8'd0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_values: state=%b rd_valid=%b dropped=%0d rd_data=%h, want 00/0/0/0", state, bus.rd_valid, dropped, bus.rd_data);
    end
    reset_n = 1'b1; cyc();
    do_arm();
    trig_opcode = 3'd6; trig_echo_msk = 4'd0; post_cnt = 5'd5;
    idle(); drive(0, 3'd6, 4'd0, 32'h10); drive(1, 3'd1, 4'd0, 32'h20); cyc(); idle();
    checks++;
    if (state !== 2'b10 || dropped !== 8'(m_dropped)) begin
      errors++; $display("FAIL mid_post: state=%b dropped=%0d, want 10/%0d", state, dropped, m_dropped);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (state !== 2'b00 || bus.rd_valid !== 1'b0 || dropped !== 8'd0) begin
      errors++; $display("FAIL reset_async: state=%b rd_valid=%b dropped=%0d, want 00/0/0", state, bus.rd_valid, dropped);
    end
    cyc(); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); drive(0, 3'd6, 4'd0, 32'($urandom)); drive(1, 3'd6, 4'd0, 32'($urandom)); cyc();
    end
    idle();
    checks++;
    if (state !== 2'(m_state) || dropped !== 8'(m_dropped) || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: state=%b dropped=%0d, want %0d/%0d", state, dropped, m_state, m_dropped);
    end
  endtask

  task automatic test_basic_window();
    logic [31:0] exp_addr [4];
    int n;
`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
    logic [15:0] ts_prev;
`endif
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h140; exp_addr[2] = 32'h180; exp_addr[3] = 32'h1C0;
    do_arm();
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL basic_armed: state=%b, want 01", state); end
    trig_opcode = 3'd6; trig_echo_msk = 4'd0; trig_echo_val = 4'($urandom); post_cnt = 5'd2;
    for (int i = 0; i < 4; i++) begin
      idle(); drive(0, (i == 1) ? 3'd6 : 3'($urandom_range(0, 5)), 4'($urandom), exp_addr[i]); cyc();
    end
    idle(); bus.rd_ready = 1'b1;
    checks++;
    if (state !== 2'b11 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done: state=%b rd_valid=%b, want 11/0", state, bus.rd_valid);
    end
    n = 0;
    for (int k = 0; k < 40 && m_state == 3; k++) begin
      checks++;
      if (bus.rd_valid !== m_rdv) begin errors++; $display("FAIL basic_rd_valid: got %b want %b", bus.rd_valid, m_rdv); end
      if (bus.rd_valid === 1'b1 && n < 4) begin
        checks++;
        if (bus.rd_data[ADDR_W-1:0] !== exp_addr[n] || m_q.size() == 0 || bus.rd_data[BASE_W-1:0] !== m_q[0]) begin
          errors++; $display("FAIL basic_entry%0d: got %h want addr %h", n, bus.rd_data, exp_addr[n]);
        end
`ifdef SIFIVE_SCOPE_TL_C_ECHO_TS_EN
        if (n > 0) begin
          checks++;
          if (bus.rd_data[ENTRY_W-1 -: 16] - ts_prev !== 16'd1) begin
            errors++; $display("FAIL basic_ts_step: got %0d want 1", bus.rd_data[ENTRY_W-1 -: 16] - ts_prev);
          end
        end
        ts_prev = bus.rd_data[ENTRY_W-1 -: 16];
`endif
        n++;
      end
      cyc();
    end
    checks++;
    if (n != 4 || state !== 2'b00 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: popped=%0d state=%b rd_valid=%b, want 4/00/0", n, state, bus.rd_valid);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_arm();
    trig_opcode = 3'd6; trig_echo_msk = 4'd0; post_cnt = 5'd4;
    for (int i = 0; i < 35; i++) begin
      idle();
      drive($urandom_range(0, 1), (i < 30) ? 3'($urandom_range(0, 5)) : 3'd6, 4'($urandom), 32'(i));
      cyc();
    end
    idle(); bus.rd_ready = 1'b1;
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL wrap_done: state=%b, want 11", state); end
    n = 0;
    for (int k = 0; k < 60 && m_state == 3; k++) begin
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (bus.rd_data[ADDR_W-1:0] !== 32'(19 + n) || m_q.size() == 0 || bus.rd_data[BASE_W-1:0] !== m_q[0]) begin
          errors++; $display("FAIL wrap_entry%0d: got addr %0d want %0d", n, bus.rd_data[ADDR_W-1:0], 19 + n);
        end
        n++;
      end
      cyc();
    end
    checks++;
    if (n != DEPTH || state !== 2'b00) begin
      errors++; $display("FAIL wrap_count: popped=%0d state=%b, want %0d/00", n, state, DEPTH);
    end
  endtask

  task automatic test_collision();
    int n;
    do_arm();
    trig_opcode = 3'd7; trig_echo_msk = 4'd0; post_cnt = 5'd0;
    for (int i = 0; i < 300; i++) begin
      idle(); drive(0, 3'd1, 4'($urandom), 32'(i)); drive(1, 3'd2, 4'($urandom), 32'h8000 + 32'(i)); cyc();
      if (i == 0) begin
        checks++;
        if (dropped !== 8'd1 || state !== 2'b01) begin
          errors++; $display("FAIL collision_one: dropped=%0d state=%b, want 1/01", dropped, state);
        end
      end
    end
    checks++;
    if (dropped !== 8'd255) begin errors++; $display("FAIL collision_sat: dropped=%0d, want 255", dropped); end
    idle(); drive(0, 3'd7, 4'd0, 32'hABC); drive(1, 3'd7, 4'd0, 32'hDEF); cyc(); idle();
    bus.rd_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && m_state == 3; k++) begin
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (bus.rd_data[BASE_W-1 -: CH_W] !== '0 || m_q.size() == 0 || bus.rd_data[BASE_W-1:0] !== m_q[0]) begin
          errors++; $display("FAIL collision_entry%0d: got %h", n, bus.rd_data);
        end
        n++;
      end
      cyc();
    end
    checks++;
    if (n != DEPTH || dropped !== 8'd255) begin
      errors++; $display("FAIL collision_drain: popped=%0d dropped=%0d, want %0d/255", n, dropped, DEPTH);
    end
  endtask

  task automatic test_echo_mask();
    do_arm();
    trig_opcode = 3'd5; trig_echo_val = 4'b0001; trig_echo_msk = 4'b0011; post_cnt = 5'd0;
    bus.rd_ready = 1'b0;
    idle(); drive(0, 3'd5, 4'b0010, 32'h1); cyc(); idle();
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL echo_no_trig: state=%b, want 01", state); end
    idle(); drive(1, 3'd4, 4'b0001, 32'h2); cyc(); idle();
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL echo_op_mismatch: state=%b, want 01", state); end
    idle(); drive(0, 3'd5, 4'b1101, 32'h3); cyc(); idle();
    checks++;
    if (state !== 2'b11 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL echo_trig: state=%b rd_valid=%b, want 11/0", state, bus.rd_valid);
    end
    cyc();
    checks++;
    if (bus.rd_valid !== 1'b1 || m_q.size() == 0 || bus.rd_data[BASE_W-1:0] !== m_q[0] || bus.rd_data[ADDR_W-1:0] !== 32'h1) begin
      errors++; $display("FAIL echo_first_entry: rd_valid=%b data=%h, want 1/addr 1", bus.rd_valid, bus.rd_data);
    end
    do_arm();
    checks++;
    if (state !== 2'b01 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL echo_rearm: state=%b rd_valid=%b, want 01/0", state, bus.rd_valid);
    end
  endtask

  task automatic test_back_pressure();
    int n, exp_n, k;
    bit stalled;
    logic [BASE_W-1:0] held;
    for (int r = 0; r < 4; r++) begin
      do_arm();
      post_cnt = 5'($urandom_range(0, 16));
      trig_opcode = 3'($urandom); trig_echo_val = 4'($urandom); trig_echo_msk = 4'($urandom);
      k = 0;
      while (m_state != 3 && k < 400) begin
        bus.c_valid = NUM_CH'($urandom); bus.c_ready = NUM_CH'($urandom);
        bus.c_opcode = 6'($urandom); bus.c_echo = 8'($urandom); bus.c_address = {$urandom, $urandom};
        if (k > 150 && m_state == 1) drive(0, trig_opcode, trig_echo_val, 32'($urandom));
        cyc(); k++;
        checks++;
        if (state !== 2'(m_state) || dropped !== 8'(m_dropped)) begin
          errors++; $display("FAIL bp_capture r%0d: state=%b dropped=%0d, want %0d/%0d", r, state, dropped, m_state, m_dropped);
        end
      end
      if (m_state != 3) begin
        checks++; errors++; $display("FAIL bp_trigger_timeout r%0d: state=%b, want 11", r, state);
      end
      exp_n = m_q.size(); n = 0; stalled = 0; held = '0; bus.rd_ready = 1'b0;
      for (int j = 0; j < 120 && m_state == 3; j++) begin
        checks++;
        if (bus.rd_valid !== m_rdv || dropped !== 8'(m_dropped)) begin
          errors++; $display("FAIL bp_drain_ctl r%0d: rd_valid=%b dropped=%0d, want %b/%0d", r, bus.rd_valid, dropped, m_rdv, m_dropped);
        end
        if (stalled) begin
          checks++;
          if (bus.rd_data[BASE_W-1:0] !== held) begin
            errors++; $display("FAIL bp_stall_hold r%0d: got %h want %h", r, bus.rd_data[BASE_W-1:0], held);
          end
        end
        if (bus.rd_valid === 1'b1 && m_q.size() != 0) begin
          checks++;
          if (bus.rd_data[BASE_W-1:0] !== m_q[0]) begin
            errors++; $display("FAIL bp_entry r%0d: got %h want %h", r, bus.rd_data[BASE_W-1:0], m_q[0]);
          end
        end
        bus.rd_ready = ~bus.rd_ready;
        bus.c_valid = NUM_CH'($urandom); bus.c_ready = NUM_CH'($urandom);
        if (bus.rd_valid === 1'b1 && bus.rd_ready) n++;
        stalled = (bus.rd_valid === 1'b1) && !bus.rd_ready;
        held = bus.rd_data[BASE_W-1:0];
        cyc();
      end
      idle();
      checks++;
      if (n != exp_n || state !== 2'b00 || bus.rd_valid !== 1'b0) begin
        errors++; $display("FAIL bp_drain_count r%0d: popped=%0d state=%b, want %0d/00", r, n, state, exp_n);
      end
    end
  endtask

  initial begin
    bus.rd_ready = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_basic_window();
    test_wrap();
    test_collision();
    test_echo_mask();
    test_back_pressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
